// File: rtl/softmax_exp_frontend_if.sv
// Score stream in, exp vector + sum out for the softmax front end.
// master = score source / result consumer, slave = softmax_exp_frontend.
interface softmax_exp_frontend_if;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic         valid_out;
  logic [31:0]  exp_sum_out;
  logic [255:0] exp_values_out;

  modport master (
    output in_valid, in_data,
    input  in_ready, valid_out, exp_sum_out, exp_values_out
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, valid_out, exp_sum_out, exp_values_out
  );
endinterface

// File: rtl/softmax_exp_frontend.sv
// Row max, exp(x - max) via 64-entry LUT, and sum; valid_out pulses 17 edges after the last beat, in_ready low meanwhile.
// Define SOFTMAX_EXP_INTERP_EN for linear interpolation between LUT entries (same latency).
module softmax_exp_frontend (
  input  logic                          clk,
  input  logic                          rst_n,
  softmax_exp_frontend_if.slave         bus
);
  typedef enum logic [1:0] {S_LOAD, S_EXP, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          r_i;
  logic signed [15:0]  r_max;
  logic [31:0]         r_acc;
  logic [15:0]         r_x  [16];
  logic [15:0]         r_ev [16];
  logic                r_valid;
  logic [31:0]         r_sum;
  logic [255:0]        r_vals;

  logic [15:0]         w_xi;
  logic [16:0]         w_t;
  logic [5:0]          w_k;
  logic [10:0]         w_e_raw;
  logic [15:0]         w_e;

  // round(1024 * exp(-k/8)); index 64 (and beyond) is the zero end point
  function automatic logic [10:0] f_lut(input logic [6:0] k);
    case (k)
      7'd0:  f_lut = 11'd1024; 7'd1:  f_lut = 11'd904;  7'd2:  f_lut = 11'd797;  7'd3:  f_lut = 11'd704;
      7'd4:  f_lut = 11'd621;  7'd5:  f_lut = 11'd548;  7'd6:  f_lut = 11'd484;  7'd7:  f_lut = 11'd427;
      7'd8:  f_lut = 11'd377;  7'd9:  f_lut = 11'd332;  7'd10: f_lut = 11'd293;  7'd11: f_lut = 11'd259;
      7'd12: f_lut = 11'd228;  7'd13: f_lut = 11'd202;  7'd14: f_lut = 11'd178;  7'd15: f_lut = 11'd157;
      7'd16: f_lut = 11'd139;  7'd17: f_lut = 11'd122;  7'd18: f_lut = 11'd108;  7'd19: f_lut = 11'd95;
      7'd20: f_lut = 11'd84;   7'd21: f_lut = 11'd74;   7'd22: f_lut = 11'd65;   7'd23: f_lut = 11'd58;
      7'd24: f_lut = 11'd51;   7'd25: f_lut = 11'd45;   7'd26: f_lut = 11'd40;   7'd27: f_lut = 11'd35;
      7'd28: f_lut = 11'd31;   7'd29: f_lut = 11'd27;   7'd30: f_lut = 11'd24;   7'd31: f_lut = 11'd21;
      7'd32: f_lut = 11'd19;   7'd33: f_lut = 11'd17;   7'd34: f_lut = 11'd15;   7'd35: f_lut = 11'd13;
      7'd36: f_lut = 11'd11;   7'd37: f_lut = 11'd10;   7'd38: f_lut = 11'd9;    7'd39: f_lut = 11'd8;
      7'd40: f_lut = 11'd7;    7'd41: f_lut = 11'd6;    7'd42: f_lut = 11'd5;    7'd43: f_lut = 11'd5;
      7'd44: f_lut = 11'd4;    7'd45: f_lut = 11'd4;    7'd46: f_lut = 11'd3;    7'd47: f_lut = 11'd3;
      7'd48: f_lut = 11'd3;    7'd49: f_lut = 11'd2;    7'd50: f_lut = 11'd2;    7'd51: f_lut = 11'd2;
      7'd52: f_lut = 11'd2;    7'd53: f_lut = 11'd1;    7'd54: f_lut = 11'd1;    7'd55: f_lut = 11'd1;
      7'd56: f_lut = 11'd1;    7'd57: f_lut = 11'd1;    7'd58: f_lut = 11'd1;    7'd59: f_lut = 11'd1;
      7'd60: f_lut = 11'd1;
      default: f_lut = 11'd0;
    endcase
  endfunction

  // max - x is at most 0xFFFF, so a 17-bit difference is always non-negative
  assign w_xi = r_x[r_i];
  assign w_t  = {r_max[15], r_max} - {w_xi[15], w_xi};
  assign w_k  = w_t[12:7];

`ifdef SOFTMAX_EXP_INTERP_EN
  logic [6:0]  w_f;
  logic [10:0] w_lut_a, w_lut_b, w_diff;
  logic [16:0] w_prod;

  assign w_f     = w_t[6:0];
  assign w_lut_a = f_lut({1'b0, w_k});
  assign w_lut_b = f_lut({1'b0, w_k} + 7'd1);
  assign w_diff  = w_lut_a - w_lut_b;
  assign w_prod  = 17'(w_diff) * 17'(w_f);
  assign w_e_raw = w_lut_a - 11'(w_prod >> 7);
`else
  assign w_e_raw = f_lut({1'b0, w_k});
`endif

  assign w_e = (w_t >= 17'h02000) ? 16'd0 : {5'd0, w_e_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  if (bus.in_valid && r_cnt == 4'd15) w_next = S_EXP;
      S_EXP:   if (r_i == 4'd15) w_next = S_DONE;
      S_DONE:  w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_i     <= 4'd0;
      r_max   <= 16'sd0;
      r_acc   <= 32'd0;
      r_valid <= 1'b0;
      r_sum   <= 32'd0;
      r_vals  <= 256'd0;
      for (int j = 0; j < 16; j++) begin
        r_x[j]  <= 16'd0;
        r_ev[j] <= 16'd0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_LOAD: if (bus.in_valid) begin
          r_x[r_cnt] <= bus.in_data;
          r_cnt      <= r_cnt + 4'd1;
          if (r_cnt == 4'd0 || $signed(bus.in_data) > r_max) r_max <= $signed(bus.in_data);
          if (r_cnt == 4'd15) r_acc <= 32'd0;
        end
        S_EXP: begin
          r_ev[r_i] <= w_e;
          r_acc     <= r_acc + {16'd0, w_e};
          r_i       <= r_i + 4'd1;
        end
        S_DONE: begin
          r_sum   <= r_acc;
          r_valid <= 1'b1;
          for (int j = 0; j < 16; j++) r_vals[16*j +: 16] <= r_ev[j];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready       = (r_state == S_LOAD);
  assign bus.valid_out      = r_valid;
  assign bus.exp_sum_out    = r_sum;
  assign bus.exp_values_out = r_vals;
endmodule

// File: tb/tb_softmax_exp_frontend.sv
// Directed bench for softmax_exp_frontend: hand-computed exp rows, latency, stalls and reset.
module tb_softmax_exp_frontend;
  typedef logic [15:0] row_t [16];

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vld_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  softmax_exp_frontend_if bus_if();

  softmax_exp_frontend dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus_if.valid_out === 1'b1) vld_cnt <= vld_cnt + 1;

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_beat(input logic [15:0] d, output bit to);
    int n;
    to = 1'b0;
    n  = 0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    while (bus_if.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) to = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_row(input row_t row, input bit gaps, input bit hold,
                         output logic [255:0] vals, output logic [31:0] sum,
                         output int lat, output int rdy_low, output bit to,
                         output logic vld_next);
    int e_cyc;
    int n;
    bit bto;
    to = 1'b0;
    rdy_low = 0;
    for (int b = 0; b < 16; b++) begin
      if (gaps) begin
        bus_if.in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      send_beat(row[b], bto);
      if (bto) to = 1'b1;
    end
    e_cyc = cyc;
    if (hold) bus_if.in_data = 16'h7FFF;
    else      bus_if.in_valid = 1'b0;
    n = 0;
    while (bus_if.valid_out !== 1'b1 && n < 60) begin
      if (bus_if.in_ready !== 1'b1) rdy_low++;
      @(negedge clk);
      n++;
    end
    bus_if.in_valid = 1'b0;
    if (n >= 60) to = 1'b1;
    lat  = cyc - e_cyc;
    vals = bus_if.exp_values_out;
    sum  = bus_if.exp_sum_out;
    @(negedge clk);
    vld_next = bus_if.valid_out;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_data  = 16'h0000;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus_if.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", bus_if.in_ready); end
    n_cmp++; if (bus_if.valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", bus_if.valid_out); end
    n_cmp++; if (bus_if.exp_sum_out !== 32'd0) begin n_err++; $display("FAIL reset_sum got %h exp 0", bus_if.exp_sum_out); end
    n_cmp++; if (bus_if.exp_values_out !== 256'd0) begin n_err++; $display("FAIL reset_values got %h exp 0", bus_if.exp_values_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zeros;
    row_t r; logic [255:0] v; logic [31:0] s; int lat, rl, v0; bit to; logic vn;
    for (int j = 0; j < 16; j++) r[j] = 16'h0000;
    v0 = vld_cnt;
    run_row(r, 1'b0, 1'b0, v, s, lat, rl, to, vn);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL zeros_timeout got %b exp 0", to); end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (v[16*j +: 16] !== 16'h0400) begin n_err++; $display("FAIL zeros_elem%0d got %h exp 0400", j, v[16*j +: 16]); end
    end
    n_cmp++; if (s !== 32'h00004000) begin n_err++; $display("FAIL zeros_sum got %h exp 00004000", s); end
    n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL zeros_latency got %0d exp 17", lat); end
    n_cmp++; if (vn !== 1'b0) begin n_err++; $display("FAIL zeros_valid_fall got %b exp 0", vn); end
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_err++; $display("FAIL zeros_pulses got %0d exp 1", vld_cnt - v0); end
  endtask

  task automatic test_peak(input bit gaps, input bit hold, input string nm);
    row_t r; logic [15:0] ex [16]; logic [255:0] v; logic [31:0] s; int lat, rl; bit to; logic vn;
    for (int j = 0; j < 16; j++) begin r[j] = 16'h0000; ex[j] = 16'h008B; end
    r[0] = 16'h0800; r[1] = 16'h0400;
    ex[0] = 16'h0400; ex[1] = 16'h0179;
    run_row(r, gaps, hold, v, s, lat, rl, to, vn);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL %s_timeout got %b exp 0", nm, to); end
    for (int j = 0; j < 16; j++) begin
      n_cmp++;
      if (v[16*j +: 16] !== ex[j]) begin n_err++; $display("FAIL %s_elem%0d got %h exp %h", nm, j, v[16*j +: 16], ex[j]); end
    end
    n_cmp++; if (s !== 32'h00000D13) begin n_err++; $display("FAIL %s_sum got %h exp 00000D13", nm, s); end
    n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL %s_latency got %0d exp 17", nm, lat); end
    if (hold) begin
      n_cmp++; if (rl !== 17) begin n_err++; $display("FAIL %s_ready_low got %0d exp 17", nm, rl); end
    end
  endtask

  task automatic test_clip;
    row_t r; logic [255:0] v; logic [31:0] s; int lat, rl; bit to; logic vn;
    for (int j = 0; j < 16; j++) r[j] = 16'hD800;
    r[0] = 16'h0000;
    run_row(r, 1'b0, 1'b0, v, s, lat, rl, to, vn);
    n_cmp++; if (v[15:0] !== 16'h0400) begin n_err++; $display("FAIL clip_elem0 got %h exp 0400", v[15:0]); end
    n_cmp++; if (v[255:16] !== 240'd0) begin n_err++; $display("FAIL clip_rest got %h exp 0", v[255:16]); end
    n_cmp++; if (s !== 32'h00000400) begin n_err++; $display("FAIL clip_sum got %h exp 00000400", s); end
  endtask

  task automatic test_back_to_back;
    row_t rz, rc; logic [255:0] v; logic [31:0] s1, s2; int lat, rl; bit to; logic vn;
    for (int j = 0; j < 16; j++) begin rz[j] = 16'h0000; rc[j] = 16'hD800; end
    rc[5] = 16'h1000;
    run_row(rz, 1'b0, 1'b0, v, s1, lat, rl, to, vn);
    run_row(rc, 1'b0, 1'b0, v, s2, lat, rl, to, vn);
    n_cmp++; if (s1 !== 32'h00004000) begin n_err++; $display("FAIL b2b_sum1 got %h exp 00004000", s1); end
    n_cmp++; if (s2 !== 32'h00000400) begin n_err++; $display("FAIL b2b_sum2 got %h exp 00000400", s2); end
    n_cmp++; if (v[95:80] !== 16'h0400) begin n_err++; $display("FAIL b2b_elem5 got %h exp 0400", v[95:80]); end
  endtask

  task automatic test_reset_mid;
    row_t r; logic [255:0] v; logic [31:0] s; int lat, rl, v0; bit to; logic vn;
    for (int j = 0; j < 16; j++) r[j] = 16'h0000;
    v0 = vld_cnt;
    for (int b = 0; b < 7; b++) send_beat(16'h0800, to);
    bus_if.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.exp_sum_out !== 32'd0) begin n_err++; $display("FAIL rstload_sum got %h exp 0", bus_if.exp_sum_out); end
    rst_n = 1'b1;
    @(negedge clk);
    run_row(r, 1'b0, 1'b0, v, s, lat, rl, to, vn);
    n_cmp++; if (s !== 32'h00004000) begin n_err++; $display("FAIL rstload_sum_after got %h exp 00004000", s); end
    n_cmp++; if (v !== {16{16'h0400}}) begin n_err++; $display("FAIL rstload_values got %h", v); end
    n_cmp++; if (vld_cnt - v0 !== 1) begin n_err++; $display("FAIL rstload_pulses got %0d exp 1", vld_cnt - v0); end
    v0 = vld_cnt;
    for (int b = 0; b < 16; b++) send_beat(16'h0100, to);
    bus_if.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.exp_values_out !== 256'd0) begin n_err++; $display("FAIL rstexp_values got %h exp 0", bus_if.exp_values_out); end
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (vld_cnt - v0 !== 0) begin n_err++; $display("FAIL rstexp_pulses got %0d exp 0", vld_cnt - v0); end
    n_cmp++; if (bus_if.exp_sum_out !== 32'd0) begin n_err++; $display("FAIL rstexp_sum got %h exp 0", bus_if.exp_sum_out); end
  endtask

  task automatic test_interp;
    row_t r; logic [255:0] v; logic [31:0] s; int lat, rl; bit to; logic vn;
    logic [15:0] e1; logic [31:0] es;
`ifdef SOFTMAX_EXP_INTERP_EN
    e1 = 16'h03C4; es = 32'h00003FC4;
`else
    e1 = 16'h0400; es = 32'h00004000;
`endif
    for (int j = 0; j < 16; j++) r[j] = 16'h0000;
    r[1] = 16'hFFC0;
    run_row(r, 1'b0, 1'b0, v, s, lat, rl, to, vn);
    n_cmp++; if (v[31:16] !== e1) begin n_err++; $display("FAIL interp_elem1 got %h exp %h", v[31:16], e1); end
    n_cmp++; if (s !== es) begin n_err++; $display("FAIL interp_sum got %h exp %h", s, es); end
    n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL interp_latency got %0d exp 17", lat); end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_peak(1'b0, 1'b0, "peak");
    test_clip();
    test_peak(1'b1, 1'b1, "gaps");
    test_back_to_back();
    test_reset_mid();
    test_interp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
